// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// sources; the winning write is registered and decoded to a one-hot enable.
module rf_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*DW-1:0]    req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [AW-1:0]         wr_addr,
    output logic [DW-1:0]         wr_data,
    output logic [(1<<AW)-1:0]    wr_en,
    output logic                  wr_valid,
    output logic [2:0]            grant_id,
    output logic                  busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   gsel;
    logic [PW-1:0]   ptr_next;
    logic [AW-1:0]   gaddr;
    logic [DW-1:0]   gdata;
    logic [NREQ-1:0] grant;
    logic            gfound;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // Handshake: a write moves when req_valid[i] & req_ready[i]; ready is a
    // pure function of ptr, stall and req_valid (never of addr/data), and a
    // requester keeps addr/data stable while valid and not yet ready.
    always_comb begin
        grant  = '0;
        gsel   = '0;
        gfound = 1'b0;
        sel    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = PW'((int'(ptr) + k) % NREQ);
            if (rst_n && !stall && !gfound && req_valid[sel]) begin
                gfound     = 1'b1;
                gsel       = sel;
                grant[sel] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign busy      = |req_valid;
    assign gaddr     = addr_arr[gsel];
    assign gdata     = data_arr[gsel];
    assign ptr_next  = PW'((int'(gsel) + 1) % NREQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= '0;
            wr_valid <= 1'b0;
            grant_id <= '0;
        end else begin
            wr_valid <= gfound;
            if (gfound) begin
                ptr      <= ptr_next;
                wr_addr  <= gaddr;
                wr_data  <= gdata;
                grant_id <= 3'(gsel);
                // x0 is hardwired: the write is still reported valid but enables nothing
                wr_en    <= (gaddr == '0) ? '0 : (NREG'(1) << gaddr);
            end else begin
                wr_en    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed table, multi-cycle reset sequence and
// random traffic compared with a behavioural round-robin model.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  wr_en;
    logic        wr_valid;
    logic [2:0]  grant_id;
    logic        busy;

    rf_write_arbiter #(.NREQ(4), .DW(16), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .wr_valid(wr_valid), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_ptr;
    logic        m_wv;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    logic [2:0]  m_gid;
    logic [7:0]  m_en;
    logic [21:0] exp_q[$];

    typedef struct {
        logic        stall;
        logic [3:0]  valid;
        logic [11:0] addr;
        logic [63:0] data;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_en;
        logic [2:0]  exp_gid;
    } vec_t;

    vec_t tbl[16];

    localparam logic [11:0] AP  = {3'd7, 3'd6, 3'd5, 3'd3};
    localparam logic [11:0] AP0 = {3'd0, 3'd6, 3'd5, 3'd3};
    localparam logic [63:0] DP  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA5A5};
    localparam logic [63:0] DX  = {16'hFFFF, 16'hC2C2, 16'hB1B1, 16'hA5A5};

    function automatic vec_t mk(input logic s, input logic [3:0] v, input logic [11:0] a,
                                input logic [63:0] d, input logic [3:0] r,
                                input logic [7:0] e, input logic [2:0] g);
        vec_t t;
        t.stall = s; t.valid = v; t.addr = a; t.data = d;
        t.exp_ready = r; t.exp_en = e; t.exp_gid = g;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wv = 1'b0; m_addr = '0; m_data = '0; m_gid = '0; m_en = '0;
        exp_q.delete();
    endtask

    // Called at posedge+1; drives one cycle, checks ready before the edge and
    // the registered write after it; returns what was observed.
    task automatic cycle(input logic s, input logic [3:0] v, input logic [11:0] a,
                         input logic [63:0] d, output logic [3:0] o_rdy,
                         output logic [7:0] o_en, output logic [2:0] o_gid,
                         output logic o_wv);
        logic       found;
        logic [1:0] gi;
        logic [1:0] idx;
        logic [21:0] got;
        stall = s; req_valid = v; req_addr = a; req_data = d;
        #1;
        found = 1'b0;
        gi = '0;
        if (!s) begin
            for (int k = 0; k < 4; k++) begin
                idx = 2'((m_ptr + k) % 4);
                if (!found && v[idx]) begin
                    found = 1'b1;
                    gi = idx;
                end
            end
        end
        check("req_ready", {60'd0, req_ready}, found ? (64'd1 << gi) : 64'd0);
        check("busy", {63'd0, busy}, {63'd0, |v});
        o_rdy = req_ready;
        @(posedge clk);
        #1;
        if (found) begin
            m_wv   = 1'b1;
            m_addr = 3'(a >> (3 * gi));
            m_data = 16'(d >> (16 * gi));
            m_gid  = 3'(gi);
            m_en   = (m_addr == 3'd0) ? 8'd0 : (8'd1 << m_addr);
            m_ptr  = (int'(gi) + 1) % 4;
            exp_q.push_back({m_gid, m_addr, m_data});
        end else begin
            m_wv = 1'b0;
            m_en = 8'd0;
        end
        check("wr_valid", {63'd0, wr_valid}, {63'd0, m_wv});
        check("wr_en", {56'd0, wr_en}, {56'd0, m_en});
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check("wr_beat", {42'd0, grant_id, wr_addr, wr_data}, {42'd0, got});
        end else begin
            check("wr_hold", {42'd0, grant_id, wr_addr, wr_data}, {42'd0, m_gid, m_addr, m_data});
        end
        o_en = wr_en; o_gid = grant_id; o_wv = wr_valid;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; req_valid = 4'hF; req_addr = AP; req_data = DP;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {40'd0, wr_addr, wr_data, wr_en, wr_valid, grant_id}, 64'd0);
        check("rst_ready", {60'd0, req_ready}, 64'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    logic [3:0] o_rdy;
    logic [7:0] o_en;
    logic [2:0] o_gid;
    logic       o_wv;

    initial begin
        tbl[0]  = mk(0, 4'b0001, AP,  DP, 4'b0001, 8'h08, 3'd0);
        tbl[1]  = mk(0, 4'b1111, AP,  DP, 4'b0010, 8'h20, 3'd1);
        tbl[2]  = mk(0, 4'b1111, AP,  DP, 4'b0100, 8'h40, 3'd2);
        tbl[3]  = mk(0, 4'b1111, AP,  DP, 4'b1000, 8'h80, 3'd3);
        tbl[4]  = mk(0, 4'b1111, AP,  DP, 4'b0001, 8'h08, 3'd0);
        tbl[5]  = mk(0, 4'b1111, AP,  DP, 4'b0010, 8'h20, 3'd1);
        tbl[6]  = mk(0, 4'b1111, AP,  DP, 4'b0100, 8'h40, 3'd2);
        tbl[7]  = mk(0, 4'b0110, AP,  DP, 4'b0010, 8'h20, 3'd1);
        tbl[8]  = mk(0, 4'b0100, AP,  DP, 4'b0100, 8'h40, 3'd2);
        tbl[9]  = mk(0, 4'b1000, AP0, DX, 4'b1000, 8'h00, 3'd3);
        tbl[10] = mk(1, 4'b0011, AP,  DP, 4'b0000, 8'h00, 3'd0);
        tbl[11] = mk(1, 4'b0011, AP,  DP, 4'b0000, 8'h00, 3'd0);
        tbl[12] = mk(1, 4'b0011, AP,  DP, 4'b0000, 8'h00, 3'd0);
        tbl[13] = mk(0, 4'b0011, AP,  DP, 4'b0001, 8'h08, 3'd0);
        tbl[14] = mk(0, 4'b0000, AP,  DP, 4'b0000, 8'h00, 3'd0);
        tbl[15] = mk(0, 4'b0011, AP,  DP, 4'b0010, 8'h20, 3'd1);

        do_reset();

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].stall, tbl[i].valid, tbl[i].addr, tbl[i].data, o_rdy, o_en, o_gid, o_wv);
            check("tbl_ready", {60'd0, o_rdy}, {60'd0, tbl[i].exp_ready});
            check("tbl_wv", {63'd0, o_wv}, {63'd0, |tbl[i].exp_ready});
            check("tbl_en", {56'd0, o_en}, {56'd0, tbl[i].exp_en});
            if (tbl[i].exp_ready != 4'd0)
                check("tbl_gid", {61'd0, o_gid}, {61'd0, tbl[i].exp_gid});
        end

        // asynchronous reset between edges while a write is pending
        cycle(0, 4'hF, AP, DP, o_rdy, o_en, o_gid, o_wv);
        cycle(0, 4'hF, AP, DP, o_rdy, o_en, o_gid, o_wv);
        check("mid_pending_wv", {63'd0, wr_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_wr_en", {56'd0, wr_en}, 64'd0);
        check("mid_wr_valid", {63'd0, wr_valid}, 64'd0);
        check("mid_ready", {60'd0, req_ready}, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0, 4'hF, AP, DP, o_rdy, o_en, o_gid, o_wv);
        check("mid_first_grant", {60'd0, o_rdy}, 64'd1);
        check("mid_first_gid", {61'd0, o_gid}, 64'd0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 12'($urandom),
                  {$urandom, $urandom}, o_rdy, o_en, o_gid, o_wv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
